// File: rtl/ps2_scan_decoder.sv
// PS/2 keyboard receiver: synchronises the raw lines, deframes 11-bit frames and strips E0/F0 prefixes.
// Optional typematic repeat suppression is enabled by defining KEY_REPEAT_FILTER_EN.
module ps2_scan_decoder #(
   parameter int SYNC_STAGES = 2,
   parameter int TIMEOUT_CLK = 5000
) (
   input  logic       clk,
   input  logic       key0_rst,
   input  logic       ps2_clk,
   input  logic       ps2_dat,
   output logic [7:0] key,
   output logic       ext,
   output logic       rdy,
   output logic       err
);

   localparam int TO_W = $clog2(TIMEOUT_CLK + 1);
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CLK - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RECV  = 2'd1,
      CHECK = 2'd2
   } state_t;

   // Odd parity: data plus parity bit must contain an odd number of ones.
   function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
      return ^{data, par};
   endfunction

   // Device status bytes that carry no key information.
   function automatic logic is_status_byte(input logic [7:0] b);
      logic hit;
      case (b)
         8'hFA, 8'hAA, 8'hEE, 8'hFE, 8'h00, 8'hFF: hit = 1'b1;
         default:                                  hit = 1'b0;
      endcase
      return hit;
   endfunction

   logic [SYNC_STAGES-1:0] clk_sync_r;
   logic [SYNC_STAGES-1:0] dat_sync_r;
   logic                   clk_prev_r;
   logic                   fall_s;
   logic                   bit_s;

   state_t           state_r;
   logic [3:0]       bit_cnt_r;
   logic [9:0]       shift_r;
   logic [TO_W-1:0]  to_cnt_r;
   logic             ext_pend_r;
   logic             brk_pend_r;
   logic [7:0]       key_r;
   logic             ext_r;
   logic             rdy_r;
   logic             err_r;

   logic [7:0]       byte_s;
   logic             frame_ok_s;

`ifdef KEY_REPEAT_FILTER_EN
   logic [8:0]       held_r;
   logic             held_vld_r;
   logic [8:0]       code_s;
`endif

   // Line synchronisers; idle PS/2 lines are high, so reset to 1 to avoid a false edge.
   always_ff @(posedge clk or negedge key0_rst) begin
      if (!key0_rst) begin
         clk_sync_r <= '1;
         dat_sync_r <= '1;
         clk_prev_r <= 1'b1;
      end else begin
         clk_sync_r <= {clk_sync_r[SYNC_STAGES-2:0], ps2_clk};
         dat_sync_r <= {dat_sync_r[SYNC_STAGES-2:0], ps2_dat};
         clk_prev_r <= clk_sync_r[SYNC_STAGES-1];
      end
   end

   // Edge detect and frame check decode.
   always_comb begin
      fall_s     = clk_prev_r & ~clk_sync_r[SYNC_STAGES-1];
      bit_s      = dat_sync_r[SYNC_STAGES-1];
      byte_s     = shift_r[7:0];
      frame_ok_s = shift_r[9] & odd_parity_ok(shift_r[7:0], shift_r[8]);
`ifdef KEY_REPEAT_FILTER_EN
      code_s     = {ext_pend_r, shift_r[7:0]};
`endif
   end

   // Receive FSM, prefix tracking and registered outputs.
   always_ff @(posedge clk or negedge key0_rst) begin
      if (!key0_rst) begin
         state_r    <= IDLE;
         bit_cnt_r  <= 4'd0;
         shift_r    <= 10'd0;
         to_cnt_r   <= '0;
         ext_pend_r <= 1'b0;
         brk_pend_r <= 1'b0;
         key_r      <= 8'h00;
         ext_r      <= 1'b0;
         rdy_r      <= 1'b0;
         err_r      <= 1'b0;
`ifdef KEY_REPEAT_FILTER_EN
         held_r     <= 9'd0;
         held_vld_r <= 1'b0;
`endif
      end else begin
         rdy_r <= 1'b0;
         err_r <= 1'b0;
         case (state_r)
            IDLE: begin
               to_cnt_r <= '0;
               if (fall_s && !bit_s) begin
                  state_r   <= RECV;
                  bit_cnt_r <= 4'd0;
               end
            end
            RECV: begin
               if (fall_s) begin
                  to_cnt_r  <= '0;
                  shift_r   <= {bit_s, shift_r[9:1]};
                  bit_cnt_r <= bit_cnt_r + 4'd1;
                  // bit_cnt 9 means this edge carries the stop bit
                  if (bit_cnt_r == 4'd9) begin
                     state_r <= CHECK;
                  end
               end else if (to_cnt_r == TO_LAST) begin
                  state_r    <= IDLE;
                  to_cnt_r   <= '0;
                  err_r      <= 1'b1;
                  ext_pend_r <= 1'b0;
                  brk_pend_r <= 1'b0;
               end else begin
                  to_cnt_r <= to_cnt_r + TO_W'(1);
               end
            end
            CHECK: begin
               state_r   <= IDLE;
               bit_cnt_r <= 4'd0;
               if (!frame_ok_s) begin
                  err_r      <= 1'b1;
                  ext_pend_r <= 1'b0;
                  brk_pend_r <= 1'b0;
               end else if (byte_s == 8'hE0) begin
                  ext_pend_r <= 1'b1;
               end else if (byte_s == 8'hF0) begin
                  brk_pend_r <= 1'b1;
               end else if (is_status_byte(byte_s)) begin
                  ext_pend_r <= ext_pend_r;
               end else if (brk_pend_r) begin
                  ext_pend_r <= 1'b0;
                  brk_pend_r <= 1'b0;
`ifdef KEY_REPEAT_FILTER_EN
                  if (code_s == held_r) begin
                     held_vld_r <= 1'b0;
                  end
`endif
               end else begin
                  ext_pend_r <= 1'b0;
                  brk_pend_r <= 1'b0;
`ifdef KEY_REPEAT_FILTER_EN
                  // Typematic repeat of the held key is swallowed.
                  if (!(held_vld_r && (code_s == held_r))) begin
                     key_r      <= byte_s;
                     ext_r      <= ext_pend_r;
                     rdy_r      <= 1'b1;
                     held_r     <= code_s;
                     held_vld_r <= 1'b1;
                  end
`else
                  key_r <= byte_s;
                  ext_r <= ext_pend_r;
                  rdy_r <= 1'b1;
`endif
               end
            end
            default: begin
               state_r <= IDLE;
            end
         endcase
      end
   end

   assign key = key_r;
   assign ext = ext_r;
   assign rdy = rdy_r;
   assign err = err_r;

endmodule

// File: tb/tb_ps2_scan_decoder.sv
// Self-checking bench for ps2_scan_decoder: frame vector table plus scoreboard of expected rdy/err events.
module tb_ps2_scan_decoder;

   localparam int SS   = 3;
   localparam int TO   = 300;
   localparam int HALF = 20;

   logic       clk      = 1'b0;
   logic       key0_rst = 1'b0;
   logic       ps2_clk  = 1'b1;
   logic       ps2_dat  = 1'b1;
   logic [7:0] key;
   logic       ext;
   logic       rdy;
   logic       err;

   ps2_scan_decoder #(.SYNC_STAGES(SS), .TIMEOUT_CLK(TO)) dut (
      .clk      (clk),
      .key0_rst (key0_rst),
      .ps2_clk  (ps2_clk),
      .ps2_dat  (ps2_dat),
      .key      (key),
      .ext      (ext),
      .rdy      (rdy),
      .err      (err)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic       is_err;
      logic [7:0] key;
      logic       ext;
   } exp_t;

   typedef struct packed {
      logic [7:0] data;
      logic       bad_par;
      logic [1:0] evt;
      logic [7:0] ekey;
      logic       eext;
   } vec_t;

   exp_t       sb_q[$];
   exp_t       mon_e;
   vec_t       vecs[18];
   int         total = 0;
   int         bad   = 0;
   logic [7:0] last_key = 8'h00;
   logic       last_ext = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic expect_rdy(input logic [7:0] k, input logic x);
      sb_q.push_back({1'b0, k, x});
      last_key = k;
      last_ext = x;
   endtask

   task automatic expect_err();
      sb_q.push_back({1'b1, last_key, last_ext});
   endtask

   task automatic send_bit(input logic b);
      @(negedge clk);
      ps2_dat = b;
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b0;
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b1;
   endtask

   task automatic gap();
      repeat (3 * HALF) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic bad_par);
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(d[i]);
      send_bit(~(^d) ^ bad_par);
      send_bit(1'b1);
      ps2_dat = 1'b1;
      gap();
   endtask

   // Scoreboard monitor: every rdy/err pulse must match the oldest expectation.
   always @(posedge clk) begin
      #1;
      if (key0_rst && (rdy || err)) begin
         check("rdy_err_excl", {31'd0, rdy & err}, 32'd0);
         if (sb_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_evt: rdy=%0b err=%0b key=%0h, none expected", rdy, err, key);
         end else begin
            mon_e = sb_q.pop_front();
            check("evt_is_err", {31'd0, err}, {31'd0, mon_e.is_err});
            check("key", {24'd0, key}, {24'd0, mon_e.key});
            check("ext", {31'd0, ext}, {31'd0, mon_e.ext});
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      logic seen;
      logic [7:0] d;

      vecs[0]  = '{8'hE0, 1'b0, 2'd0, 8'h00, 1'b0};
      vecs[1]  = '{8'h75, 1'b0, 2'd1, 8'h75, 1'b1};
      vecs[2]  = '{8'hE0, 1'b0, 2'd0, 8'h00, 1'b0};
      vecs[3]  = '{8'hF0, 1'b0, 2'd0, 8'h00, 1'b0};
      vecs[4]  = '{8'h75, 1'b0, 2'd0, 8'h00, 1'b0};
      vecs[5]  = '{8'h16, 1'b0, 2'd1, 8'h16, 1'b0};
      vecs[6]  = '{8'h1D, 1'b1, 2'd2, 8'h16, 1'b0};
      vecs[7]  = '{8'h1C, 1'b0, 2'd1, 8'h1C, 1'b0};
      vecs[8]  = '{8'hFA, 1'b0, 2'd0, 8'h00, 1'b0};
      vecs[9]  = '{8'hE0, 1'b0, 2'd0, 8'h00, 1'b0};
      vecs[10] = '{8'hAA, 1'b0, 2'd0, 8'h00, 1'b0};
      vecs[11] = '{8'h4A, 1'b0, 2'd1, 8'h4A, 1'b1};
      vecs[12] = '{8'hE0, 1'b0, 2'd0, 8'h00, 1'b0};
      vecs[13] = '{8'h2B, 1'b1, 2'd2, 8'h4A, 1'b1};
      vecs[14] = '{8'h2B, 1'b0, 2'd1, 8'h2B, 1'b0};
      vecs[15] = '{8'hF0, 1'b0, 2'd0, 8'h00, 1'b0};
      vecs[16] = '{8'h2B, 1'b0, 2'd0, 8'h00, 1'b0};
      vecs[17] = '{8'h34, 1'b0, 2'd1, 8'h34, 1'b0};

      // Reset state
      repeat (4) @(negedge clk);
      check("rst_key", {24'd0, key}, 32'd0);
      check("rst_ext", {31'd0, ext}, 32'd0);
      check("rst_rdy", {31'd0, rdy}, 32'd0);
      check("rst_err", {31'd0, err}, 32'd0);
      key0_rst = 1'b1;
      gap();

      // Frame 0x1D with latency measured from the raw stop edge
      d = 8'h1D;
      expect_rdy(8'h1D, 1'b0);
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(d[i]);
      send_bit(~(^d));
      @(negedge clk);
      ps2_dat = 1'b1;
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b0;
      n = 0;
      seen = 1'b0;
      while (n < 20 && !seen) begin
         @(posedge clk);
         #1;
         n++;
         if (rdy) seen = 1'b1;
      end
      check("latency", n, SS + 2);
      @(negedge clk);
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b1;
      gap();

      // Start bit of 1 is a glitch: ignored without error
      send_bit(1'b1);
      gap();
      expect_rdy(8'h5A, 1'b0);
      send_frame(8'h5A, 1'b0);

      // Table-driven frames
      for (int v = 0; v < 18; v++) begin
         if (vecs[v].evt == 2'd1) begin
            expect_rdy(vecs[v].ekey, vecs[v].eext);
         end else if (vecs[v].evt == 2'd2) begin
            sb_q.push_back({1'b1, vecs[v].ekey, vecs[v].eext});
         end
         send_frame(vecs[v].data, vecs[v].bad_par);
      end

      // Timeout after 6 bits
      expect_err();
      send_bit(1'b0);
      for (int i = 0; i < 5; i++) send_bit(1'b1);
      ps2_dat = 1'b1;
      repeat (TO + 10) @(negedge clk);
      expect_rdy(8'h23, 1'b0);
      send_frame(8'h23, 1'b0);

      // Reset mid-frame after 5 bits
      send_bit(1'b0);
      for (int i = 0; i < 4; i++) send_bit(1'b0);
      @(negedge clk);
      key0_rst = 1'b0;
      repeat (3) @(negedge clk);
      check("midrst_key", {24'd0, key}, 32'd0);
      check("midrst_ext", {31'd0, ext}, 32'd0);
      check("midrst_rdy", {31'd0, rdy}, 32'd0);
      check("midrst_err", {31'd0, err}, 32'd0);
      ps2_dat = 1'b1;
      key0_rst = 1'b1;
      last_key = 8'h00;
      last_ext = 1'b0;
      gap();
      expect_rdy(8'h1B, 1'b0);
      send_frame(8'h1B, 1'b0);

      // Typematic repeat: 1D 1D 1D F0 1D 1D
      expect_rdy(8'h1D, 1'b0);
      send_frame(8'h1D, 1'b0);
`ifndef KEY_REPEAT_FILTER_EN
      expect_rdy(8'h1D, 1'b0);
`endif
      send_frame(8'h1D, 1'b0);
`ifndef KEY_REPEAT_FILTER_EN
      expect_rdy(8'h1D, 1'b0);
`endif
      send_frame(8'h1D, 1'b0);
      send_frame(8'hF0, 1'b0);
      send_frame(8'h1D, 1'b0);
      expect_rdy(8'h1D, 1'b0);
      send_frame(8'h1D, 1'b0);

      repeat (50) @(negedge clk);
      check("drain", sb_q.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
